// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU issue stage: ALU select codes, default
// widths and the sequencer FSM state encoding.
package alu_op_sequencer_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Select codes understood by alu_8bit
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// Synchronous command FIFO. Head entry is visible on o_rdata whenever the
// FIFO is not empty; push is refused while full, pop while empty.
module alu_op_sequencer_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  // DEPTH is a power of two, so pointers wrap naturally at their width
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == {CW{1'b0}});
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage array: written at the tail on an accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for alu_8bit: buffers commands, drives registered operands and
// select into the ALU, captures result/carry and keeps an accumulator so
// that commands with acc=1 chain on the previous result.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_sel,
  input  logic              in_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_carry
);

  // Entry layout: {a, b, sel, acc}
  localparam int CMD_W = DATA_W * 2 + 3;

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CMD_W-1:0]  w_wdata;
  logic [CMD_W-1:0]  w_rdata;
  logic [DATA_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_b;
  logic [1:0]        w_head_sel;
  logic              w_head_acc;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [1:0]        r_alu_sel;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic              r_out_carry;

  assign in_ready   = !w_full;
  assign w_wdata    = {in_a, in_b, in_sel, in_acc};
  assign w_head_a   = w_rdata[CMD_W-1 -: DATA_W];
  assign w_head_b   = w_rdata[DATA_W+2 -: DATA_W];
  assign w_head_sel = w_rdata[2:1];
  assign w_head_acc = w_rdata[0];

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;

  alu_op_sequencer_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and pop decision: a pop is always an issue into the ALU
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_EXEC;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Issue registers: loaded only on pop, so they hold steady otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= {DATA_W{1'b0}};
      r_alu_b   <= {DATA_W{1'b0}};
      r_alu_sel <= 2'b00;
    end else if (w_pop) begin
      r_alu_a   <= w_head_acc ? r_acc : w_head_a;
      r_alu_b   <= w_head_b;
      r_alu_sel <= w_head_sel;
    end
  end

  // Result capture in EXEC; accumulator updates there, ahead of the next issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= {DATA_W{1'b0}};
      r_out_valid  <= 1'b0;
      r_out_result <= {DATA_W{1'b0}};
      r_out_carry  <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_acc        <= alu_result;
      r_out_result <= alu_result;
      r_out_carry  <= alu_carry;
      r_out_valid  <= 1'b1;
    end else if ((r_state == ST_DONE) && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural alu_8bit in the loop.
// Expected {carry,result} pairs are queued when a command is accepted and
// compared in order whenever a result is handed off.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;
  logic [1:0] in_sel = 2'b00;
  logic       in_acc = 1'b0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic       out_carry;
  logic [8:0] alu_wide;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
    logic       acc;
    logic [7:0] er;
    logic       ec;
  } vec_t;
  vec_t vecs[9];

  alu_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .in_acc     (in_acc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry)
  );

  always #5 clk = ~clk;

  // Behavioural alu_8bit: 9-bit arithmetic, bit 8 is carry (borrow for SUB)
  always_comb begin
    case (alu_sel)
      ALU_ADD: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      ALU_AND: alu_wide = {1'b0, alu_a & alu_b};
      ALU_OR:  alu_wide = {1'b0, alu_a | alu_b};
      default: alu_wide = 9'd0;
    endcase
  end
  assign alu_result = alu_wide[7:0];
  assign alu_carry  = alu_wide[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard: a handoff happens on the next rising edge when valid&&ready here
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("result", 32'({out_carry, out_result}), 32'(e));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                          input logic acc, input logic [8:0] expv);
    int waited = 0;
    in_a = a; in_b = b; in_sel = sel; in_acc = acc; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(expv);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{8'd255, 8'd1,   ALU_ADD, 1'b0, 8'd0,   1'b1};
    vecs[1] = '{8'd20,  8'd4,   ALU_SUB, 1'b0, 8'd16,  1'b0};
    vecs[2] = '{8'd10,  8'd5,   ALU_ADD, 1'b0, 8'd15,  1'b0};
    vecs[3] = '{8'd0,   8'd3,   ALU_ADD, 1'b1, 8'd18,  1'b0};
    vecs[4] = '{8'd0,   8'hF0,  ALU_AND, 1'b1, 8'h10,  1'b0};
    vecs[5] = '{8'h0F,  8'hA0,  ALU_OR,  1'b0, 8'hAF,  1'b0};
    vecs[6] = '{8'd3,   8'd5,   ALU_SUB, 1'b0, 8'hFE,  1'b1};
    vecs[7] = '{8'd0,   8'd1,   ALU_ADD, 1'b1, 8'hFF,  1'b0};
    vecs[8] = '{8'd0,   8'd1,   ALU_ADD, 1'b1, 8'h00,  1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_regs", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("rst_out_regs", 32'({out_carry, out_result}), 32'd0);
    tick();

    // Latency from accept to out_valid with an idle, empty sequencer
    push_cmd(8'd10, 8'd5, ALU_ADD, 1'b0, 9'd15);
    @(negedge clk);
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_c3_valid", 32'(out_valid), 32'd1);
    check("lat_c3_result", 32'({out_carry, out_result}), 32'd15);
    tick();
    wait_drain();

    // Table of commands, issued back to back, including accumulate chains
    for (int i = 0; i < 9; i++) begin
      push_cmd(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].acc, {vecs[i].ec, vecs[i].er});
    end
    wait_drain();

    // Backpressure: 1 held in DONE + 4 buffered, then release
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(8'(i * 10 + 1), 8'(i), ALU_ADD, 1'b0, 9'(i * 11 + 1));
    end
    in_a = 8'hEE; in_b = 8'hEE; in_sel = ALU_OR; in_acc = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'({out_carry, out_result}), 32'd1);
    end
    tick();
    in_valid = 1'b0;
    check("full_count", 32'(dut.u_fifo.r_count), 32'd4);
    out_ready = 1'b1;
    wait_drain();

    // Simultaneous push and pop at count 2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_cmd(8'(i + 40), 8'd2, ALU_ADD, 1'b0, 9'(i + 42));
    end
    repeat (3) tick();
    check("pp_count_before", 32'(dut.u_fifo.r_count), 32'd2);
    check("pp_state_done", 32'(dut.r_state), 32'(ST_DONE));
    in_a = 8'd60; in_b = 8'd3; in_sel = ALU_SUB; in_acc = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("pp_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(9'd57);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_count_after", 32'(dut.u_fifo.r_count), 32'd2);
    tick();
    out_ready = 1'b1;
    wait_drain();

    // Eight more pushes: pointers wrap, order must be preserved
    for (int i = 0; i < 8; i++) begin
      push_cmd(8'(i * 3), 8'd100, ALU_ADD, 1'b0, 9'(i * 3 + 100));
    end
    wait_drain();

    // Reset while in EXEC with 3 commands still queued
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(8'(i + 1), 8'd1, ALU_ADD, 1'b0, 9'(i + 2));
    end
    repeat (2) tick();
    out_ready = 1'b1;
    tick();
    check("mid_state_exec", 32'(dut.r_state), 32'(ST_EXEC));
    check("mid_count", 32'(dut.u_fifo.r_count), 32'd3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("mid_rst_out", 32'({out_valid, out_carry, out_result}), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    tick();
    // Accumulator must be cleared: 0 + 7
    push_cmd(8'd99, 8'd7, ALU_ADD, 1'b1, 9'd7);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
